// File: rtl/tow_game_ctrl.sv
// Round sequencer for the tug-of-war reaction game: darkness, all-on wait,
// random delay, then either a fake round or live play until a player wins.
module tow_game_ctrl #(
  parameter int DARK_MS = 500,
  parameter int WAIT_MS = 1000,
  parameter int STEP_MS = 100,
  parameter int FAKE_MS = 1000,
  parameter int END_MS  = 3000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_ms,
  input  logic       start_btn,
  input  logic [3:0] rand_delay,
  input  logic       fake_en,
  input  logic [6:0] score,
  output logic [2:0] led_control,
  output logic       score_enable,
  output logic       win_l,
  output logic       win_r,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_RST_DISP = 3'd0,
    S_DARK     = 3'd1,
    S_WAIT     = 3'd2,
    S_DELAY    = 3'd3,
    S_FAKE     = 3'd4,
    S_PLAY     = 3'd5,
    S_END      = 3'd6
  } state_t;

  localparam logic [11:0] DARK_LAST = 12'(DARK_MS - 1);
  localparam logic [11:0] WAIT_LAST = 12'(WAIT_MS - 1);
  localparam logic [11:0] FAKE_LAST = 12'(FAKE_MS - 1);
  localparam logic [11:0] END_LAST  = 12'(END_MS - 1);
  localparam logic [11:0] STEP_C    = 12'(STEP_MS);

  localparam logic [6:0] SCORE_LEFT  = 7'b1000000;
  localparam logic [6:0] SCORE_RIGHT = 7'b0000001;

  state_t      state;
  state_t      next_state;
  logic [11:0] ms_cnt;
  logic        start_prev;
  logic [3:0]  rand_s;
  logic        fake_s;
  logic        start_edge;
  logic        entering;
  logic        timer_done;
  logic [11:0] cur_last;
  logic [11:0] delay_dur;

  assign start_edge = start_btn & ~start_prev;
  assign entering   = (next_state != state);
  assign state_dbg  = state;

  // Delay length is (steps+1)*STEP_MS; max 1600 fits in the 12-bit counter.
  always_comb begin
    delay_dur = ({8'd0, rand_s} + 12'd1) * STEP_C;
    cur_last  = '0;
    case (state)
      S_DARK:  cur_last = DARK_LAST;
      S_WAIT:  cur_last = WAIT_LAST;
      S_DELAY: cur_last = delay_dur - 12'd1;
      S_FAKE:  cur_last = FAKE_LAST;
      S_END:   cur_last = END_LAST;
      default: cur_last = '0;
    endcase
    timer_done = tick_ms && (ms_cnt == cur_last);
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RST_DISP: if (start_edge) next_state = S_DARK;
      S_DARK:     if (timer_done) next_state = S_WAIT;
      S_WAIT:     if (timer_done) next_state = S_DELAY;
      S_DELAY:    if (timer_done) next_state = fake_s ? S_FAKE : S_PLAY;
      S_FAKE:     if (timer_done) next_state = S_DARK;
      S_PLAY:     if (score == SCORE_LEFT || score == SCORE_RIGHT) next_state = S_END;
      S_END:      if (timer_done) next_state = S_RST_DISP;
      default:    next_state = S_RST_DISP;
    endcase
  end

  always_comb begin
    led_control  = 3'b001;
    score_enable = 1'b0;
    case (state)
      S_RST_DISP: led_control = 3'b001;
      S_DARK:     led_control = 3'b000;
      S_WAIT:     led_control = 3'b010;
      S_DELAY:    led_control = 3'b000;
      S_FAKE:     led_control = 3'b100;
      S_PLAY: begin
        led_control  = 3'b011;
        score_enable = 1'b1;
      end
      S_END:      led_control = 3'b110;
      default:    led_control = 3'b001;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RST_DISP;
    else          state <= next_state;
  end

  // start_prev resets high so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms_cnt     <= '0;
      start_prev <= 1'b1;
      rand_s     <= '0;
      fake_s     <= 1'b0;
      win_l      <= 1'b0;
      win_r      <= 1'b0;
    end else begin
      start_prev <= start_btn;
      if (entering)     ms_cnt <= '0;
      else if (tick_ms) ms_cnt <= ms_cnt + 12'd1;
      if (entering && next_state == S_DELAY) begin
        rand_s <= rand_delay;
        fake_s <= fake_en;
      end
      if (state == S_PLAY && next_state == S_END) begin
        win_l <= (score == SCORE_LEFT);
        win_r <= (score == SCORE_RIGHT);
      end else if (entering && next_state == S_RST_DISP) begin
        win_l <= 1'b0;
        win_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tow_game_ctrl.md
TOW_GAME_CTRL -- requirements
Module: tow_game_ctrl

Interface
REQ-001 Parameter DARK_MS, default 500, meaning dark-state duration in ms.
REQ-002 Parameter WAIT_MS, default 1000, meaning all-LEDs-on wait duration in ms.
REQ-003 Parameter STEP_MS, default 100, meaning random-delay granularity in ms.
REQ-004 Parameter FAKE_MS, default 1000, meaning fake-round display duration in ms.
REQ-005 Parameter END_MS, default 3000, meaning end-of-game speed display duration in ms.
REQ-006 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-007 Port reset_n, input, 1, reset: asynchronous, active-low.
REQ-008 Port tick_ms, input, 1, one-clk-wide enable pulse once per millisecond.
REQ-009 Port start_btn, input, 1, debounced, synchronized start button level.
REQ-010 Port rand_delay, input, 4, random delay step count from the LFSR block.
REQ-011 Port fake_en, input, 1, request that the next round be a fake round.
REQ-012 Port score, input, 7, one-hot rope position from the scorer.
REQ-013 Port led_control, output, 3, display select code for the LED mux.
REQ-014 Port score_enable, output, 1, high only in PLAY; scorer accepts presses only while high.
REQ-015 Port win_l, output, 1, high from entry to END while left player has won.
REQ-016 Port win_r, output, 1, high from entry to END while right player has won.

Function
REQ-017 States and led_control codes: RST_DISP=001, DARK=000, WAIT=010, DELAY=000, FAKE=100, PLAY=011, END=110.
REQ-018 A 12-bit ms counter clears on every state entry and increments on each clk where tick_ms=1.
REQ-019 A timed state exits on the clk where tick_ms=1 and the counter equals its duration minus 1; a state of duration N thus lasts exactly N ticks.
REQ-020 Start edge: start_btn=1 with a registered previous value of 0; the previous-value register resets to 1 so a button held through reset does not start a game.
REQ-021 RST_DISP -> DARK on a start edge; start edges in every other state are ignored.
REQ-022 DARK -> WAIT after DARK_MS; WAIT -> DELAY after WAIT_MS.
REQ-023 fake_en and rand_delay are sampled into registers on the clk that enters DELAY; later changes have no effect until the next DELAY entry.
REQ-024 DELAY lasts (rand_delay_sampled+1)*STEP_MS ticks, range 100..1600 ms at defaults; the product is computed at 12 bits without overflow.
REQ-025 DELAY exit goes to FAKE if fake_sampled=1, else to PLAY.
REQ-026 FAKE -> DARK after FAKE_MS; score_enable stays 0 and presses have no effect.
REQ-027 In PLAY: score=7'b1000000 -> END with win_l=1; score=7'b0000001 -> END with win_r=1; any other value stays in PLAY with no timeout.
REQ-028 In PLAY, the win check is combinational on score; END is entered on the next clk edge and score_enable drops in that same cycle.
REQ-029 END -> RST_DISP after END_MS; win_l and win_r clear on the RST_DISP entry.
REQ-030 Illegal state encodings -> RST_DISP on the next clk.
REQ-031 Outputs are registered or decoded from the state register only; no input reaches an output combinationally.

Reset
REQ-032 reset_n=0 immediately forces: state RST_DISP, led_control=001, score_enable=0, win_l=0, win_r=0, counter=0, sampled registers=0, start previous-value register=1.
REQ-033 Reset asserted mid-state (including PLAY and END) aborts the game with no further outputs; after release the block waits for a fresh start edge.

Verification
REQ-034 Reset released with start_btn held at 1 -> stays in RST_DISP with led_control=001; release then press -> DARK (000) on the clk after the edge.
REQ-035 Start with rand_delay=3, fake_en=0 -> DARK 500 ticks, WAIT (010) 1000 ticks, DELAY 400 ticks, then PLAY (011) with score_enable=1.
REQ-036 fake_en=1 at DELAY entry, cleared 1 clk later -> FAKE (100) for 1000 ticks, then DARK; score_enable=0 throughout.
REQ-037 In PLAY, drive score=7'b0000001 -> next clk END (110), win_r=1, score_enable=0; after 3000 ticks -> RST_DISP, win_r=0.
REQ-038 rand_delay=15 -> DELAY lasts exactly 1600 ticks; rand_delay changed mid-DELAY -> duration unchanged.
REQ-039 reset_n pulsed low mid-PLAY -> led_control=001 and score_enable=0 asynchronously, before the next clk edge.
